// File: rtl/prci_rst_seq_pkg.sv
// Shared types and constants for the PRCI reset sequencer: state encoding,
// reset-cause codes and the packed register image used by prci_rst_seq.
package prci_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_DBG_REL   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_POWER = 2'd0;
    localparam logic [1:0] CAUSE_LOCK  = 2'd1;
    localparam logic [1:0] CAUSE_SOFT  = 2'd2;
    localparam logic [1:0] CAUSE_WDOG  = 2'd3;

    // Everything the sequencer keeps between cycles, outputs included.
    typedef struct packed {
        state_t      state;
        logic [15:0] cnt;
        logic [15:0] wdog;
        logic        sys_rst;
        logic        dbg_nrst;
        logic        pcie_nrst;
        logic        soft_ack;
        logic [1:0]  cause;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:     ST_HOLD,
        cnt:       16'd0,
        wdog:      16'd0,
        sys_rst:   1'b1,
        dbg_nrst:  1'b0,
        pcie_nrst: 1'b0,
        soft_ack:  1'b0,
        cause:     CAUSE_POWER
    };

    // Counters are compared against cycles-1 so each state exits on its terminal count.
    function automatic logic [15:0] term_count(input int unsigned cycles);
        term_count = 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/prci_rst_seq.sv
// PRCI reset sequencer: PLL-lock qualified release of debug, system and PCIe
// domains, plus soft reset. Optional watchdog enabled by PRCI_RST_SEQ_WDOG_EN.
module prci_rst_seq
    import prci_rst_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned RELEASE_GAP     = 8,
    parameter int unsigned SOFT_RST_CYCLES = 32,
    parameter int unsigned WDOG_CYCLES     = 65535
) (
    input  logic       i_clk,
    input  logic       i_pwrreset,
    input  logic       i_sys_locked,
    input  logic       i_ddr_locked,
    input  logic       i_dmireset,
    input  logic       i_pcie_phy_rst,
    input  logic       i_pcie_phy_lnk_up,
    input  logic       i_soft_req,
    output logic       o_soft_ack,
    input  logic       i_wdog_kick,
    output logic       o_sys_rst,
    output logic       o_sys_nrst,
    output logic       o_dbg_nrst,
    output logic       o_pcie_nrst,
    output logic [2:0] o_state,
    output logic [1:0] o_rst_cause
);

    localparam logic [15:0] STABLE_TERM = term_count(STABLE_CYCLES);
    localparam logic [15:0] GAP_TERM    = term_count(RELEASE_GAP);
    localparam logic [15:0] SOFT_TERM   = term_count(SOFT_RST_CYCLES);
    localparam logic [15:0] WDOG_TERM   = term_count(WDOG_CYCLES);

    regs_t r;
    regs_t nxt;
    logic  locks_ok;
    logic  wdog_fire;
    logic  stay_run;

    assign locks_ok = i_sys_locked & i_ddr_locked;

`ifndef PRCI_RST_SEQ_WDOG_EN
    logic unused_wdog;
    assign unused_wdog = ^{i_wdog_kick, WDOG_TERM};
`endif

    always_ff @(posedge i_clk) begin
        if (i_pwrreset) begin
            r <= REGS_RESET;
        end else begin
            r <= nxt;
        end
    end

    always_comb begin
        nxt          = r;
        nxt.soft_ack = 1'b0;
        wdog_fire    = 1'b0;
        stay_run     = 1'b0;

        // Lock loss overrides everything below; LOCK_WAIT keeps the earlier cause.
        if ((r.state != ST_HOLD) && !locks_ok) begin
            nxt.state = ST_LOCK_WAIT;
            nxt.cnt   = '0;
            if (r.state != ST_LOCK_WAIT) begin
                nxt.cause = CAUSE_LOCK;
            end
        end else begin
            case (r.state)
                ST_HOLD: begin
                    nxt.state = ST_LOCK_WAIT;
                    nxt.cnt   = '0;
                end
                ST_LOCK_WAIT: begin
                    if (r.cnt == STABLE_TERM) begin
                        nxt.state = ST_DBG_REL;
                        nxt.cnt   = '0;
                    end else begin
                        nxt.cnt = r.cnt + 16'd1;
                    end
                end
                ST_DBG_REL: begin
                    if (r.cnt == GAP_TERM) begin
                        nxt.state = ST_RUN;
                        nxt.cnt   = '0;
                        nxt.wdog  = '0;
                    end else begin
                        nxt.cnt = r.cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    stay_run = 1'b1;
`ifdef PRCI_RST_SEQ_WDOG_EN
                    if (i_wdog_kick) begin
                        nxt.wdog = '0;
                    end else if (r.wdog == WDOG_TERM) begin
                        wdog_fire = 1'b1;
                    end else begin
                        nxt.wdog = r.wdog + 16'd1;
                    end
`endif
                    if (wdog_fire) begin
                        nxt.state = ST_SOFT;
                        nxt.cnt   = '0;
                        nxt.cause = CAUSE_WDOG;
                        stay_run  = 1'b0;
                    end else if (i_soft_req) begin
                        nxt.state    = ST_SOFT;
                        nxt.cnt      = '0;
                        nxt.soft_ack = 1'b1;
                        nxt.cause    = CAUSE_SOFT;
                        stay_run     = 1'b0;
                    end
                end
                ST_SOFT: begin
                    if (r.cnt == SOFT_TERM) begin
                        nxt.state = ST_DBG_REL;
                        nxt.cnt   = '0;
                    end else begin
                        nxt.cnt = r.cnt + 16'd1;
                    end
                end
                default: begin
                    nxt = REGS_RESET;
                end
            endcase
        end

        // Reset outputs follow the state being entered; PCIe waits one RUN cycle.
        case (nxt.state)
            ST_DBG_REL, ST_SOFT: begin
                nxt.sys_rst   = 1'b1;
                nxt.dbg_nrst  = 1'b1;
                nxt.pcie_nrst = 1'b0;
            end
            ST_RUN: begin
                nxt.sys_rst   = i_dmireset;
                nxt.dbg_nrst  = 1'b1;
                nxt.pcie_nrst = stay_run & i_pcie_phy_lnk_up & ~i_pcie_phy_rst & ~i_dmireset;
            end
            default: begin
                nxt.sys_rst   = 1'b1;
                nxt.dbg_nrst  = 1'b0;
                nxt.pcie_nrst = 1'b0;
            end
        endcase
    end

    assign o_sys_rst   = r.sys_rst;
    assign o_sys_nrst  = ~r.sys_rst;
    assign o_dbg_nrst  = r.dbg_nrst;
    assign o_pcie_nrst = r.pcie_nrst;
    assign o_soft_ack  = r.soft_ack;
    assign o_state     = r.state;
    assign o_rst_cause = r.cause;

endmodule

// File: tb/tb_prci_rst_seq.sv
// Directed bench for prci_rst_seq with hand-derived edge-by-edge expectations.
// Watchdog section is compiled only with PRCI_RST_SEQ_WDOG_EN.
`timescale 1ns/1ps
module tb_prci_rst_seq;

    logic       i_clk = 1'b0;
    logic       i_pwrreset;
    logic       i_sys_locked;
    logic       i_ddr_locked;
    logic       i_dmireset;
    logic       i_pcie_phy_rst;
    logic       i_pcie_phy_lnk_up;
    logic       i_soft_req;
    logic       o_soft_ack;
    logic       i_wdog_kick;
    logic       o_sys_rst;
    logic       o_sys_nrst;
    logic       o_dbg_nrst;
    logic       o_pcie_nrst;
    logic [2:0] o_state;
    logic [1:0] o_rst_cause;

    int vectors     = 0;
    int miscompares = 0;

    prci_rst_seq #(
        .STABLE_CYCLES  (16),
        .RELEASE_GAP    (8),
        .SOFT_RST_CYCLES(32),
        .WDOG_CYCLES    (100)
    ) dut (
        .i_clk            (i_clk),
        .i_pwrreset       (i_pwrreset),
        .i_sys_locked     (i_sys_locked),
        .i_ddr_locked     (i_ddr_locked),
        .i_dmireset       (i_dmireset),
        .i_pcie_phy_rst   (i_pcie_phy_rst),
        .i_pcie_phy_lnk_up(i_pcie_phy_lnk_up),
        .i_soft_req       (i_soft_req),
        .o_soft_ack       (o_soft_ack),
        .i_wdog_kick      (i_wdog_kick),
        .o_sys_rst        (o_sys_rst),
        .o_sys_nrst       (o_sys_nrst),
        .o_dbg_nrst       (o_dbg_nrst),
        .o_pcie_nrst      (o_pcie_nrst),
        .o_state          (o_state),
        .o_rst_cause      (o_rst_cause)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs set beforehand are sampled on the next edge; outputs are read 1ns later.
    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkSeq(input string tag, input int st, input int dbg, input int sysn, input int pcie);
        checkOutput({tag, " state"}, 32'(o_state), 32'(st));
        checkOutput({tag, " dbg_nrst"}, 32'(o_dbg_nrst), 32'(dbg));
        checkOutput({tag, " sys_nrst"}, 32'(o_sys_nrst), 32'(sysn));
        checkOutput({tag, " sys_rst"}, 32'(o_sys_rst), 32'(sysn == 0));
        checkOutput({tag, " pcie_nrst"}, 32'(o_pcie_nrst), 32'(pcie));
    endtask

    task automatic checkReset(input string tag);
        checkSeq(tag, 0, 0, 0, 0);
        checkOutput({tag, " soft_ack"}, 32'(o_soft_ack), 0);
        checkOutput({tag, " cause"}, 32'(o_rst_cause), 0);
    endtask

    initial begin
        i_pwrreset        = 1'b1;
        i_sys_locked      = 1'b0;
        i_ddr_locked      = 1'b0;
        i_dmireset        = 1'b0;
        i_pcie_phy_rst    = 1'b0;
        i_pcie_phy_lnk_up = 1'b0;
        i_soft_req        = 1'b0;
        i_wdog_kick       = 1'b0;
        repeat (3) applyStimulus();
        checkReset("por");

        // Startup: locks high from E1, link up.
        i_pwrreset        = 1'b0;
        i_sys_locked      = 1'b1;
        i_ddr_locked      = 1'b1;
        i_pcie_phy_lnk_up = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            applyStimulus();
            checkSeq($sformatf("start E%0d", k),
                     (k <= 16) ? 1 : (k <= 24) ? 2 : 3,
                     int'(k >= 17), int'(k >= 25), int'(k >= 26));
        end
        checkOutput("start cause", 32'(o_rst_cause), 0);

        // i_dmireset for 5 edges in RUN.
        for (int j = 1; j <= 7; j++) begin
            i_dmireset = (j <= 5);
            applyStimulus();
            checkSeq($sformatf("dmi E%0d", j), 3, 1, int'(j > 5), int'(j > 5));
        end
        i_dmireset = 1'b0;

        // Soft pulse in RUN, then a request during DBG_REL that must be ignored.
        for (int n = 1; n <= 42; n++) begin
            i_soft_req = (n == 1) || (n == 35);
            applyStimulus();
            checkSeq($sformatf("soft E%0d", n),
                     (n <= 32) ? 4 : (n <= 40) ? 2 : 3,
                     1, int'(n >= 41), int'(n >= 42));
            checkOutput($sformatf("soft E%0d ack", n), 32'(o_soft_ack), 32'(n == 1));
            checkOutput($sformatf("soft E%0d cause", n), 32'(o_rst_cause), 2);
        end
        i_soft_req = 1'b0;

        // Lock loss in RUN and full resequence after relock.
        for (int n = 0; n <= 25; n++) begin
            i_sys_locked = (n != 0);
            applyStimulus();
            checkSeq($sformatf("lockloss E%0d", n),
                     (n <= 15) ? 1 : (n <= 23) ? 2 : 3,
                     int'(n >= 16), int'(n >= 24), int'(n >= 25));
            checkOutput($sformatf("lockloss E%0d cause", n), 32'(o_rst_cause), 1);
        end

        // Power reset from RUN applies reset values after the same edge.
        i_pwrreset = 1'b1;
        applyStimulus();
        checkReset("pwr mid");
        i_pwrreset = 1'b0;

        // Restart with a one-cycle DDR glitch while LOCK_WAIT cnt=10.
        for (int k = 1; k <= 36; k++) begin
            i_ddr_locked = (k != 12);
            applyStimulus();
            checkSeq($sformatf("glitch E%0d", k),
                     (k <= 27) ? 1 : (k <= 35) ? 2 : 3,
                     int'(k >= 28), int'(k >= 36), 0);
            checkOutput($sformatf("glitch E%0d cause", k), 32'(o_rst_cause), 0);
        end
        i_ddr_locked = 1'b1;

`ifdef PRCI_RST_SEQ_WDOG_EN
        // RUN was entered at E36; no kick -> SOFT after E136 with cause 3.
        for (int k = 37; k <= 136; k++) begin
            applyStimulus();
            checkOutput($sformatf("wdog E%0d state", k), 32'(o_state), (k < 136) ? 3 : 4);
        end
        checkOutput("wdog cause", 32'(o_rst_cause), 3);
        checkOutput("wdog ack", 32'(o_soft_ack), 0);
        for (int k = 137; k <= 176; k++) begin
            applyStimulus();
        end
        checkOutput("wdog rerun state", 32'(o_state), 3);
        for (int j = 1; j <= 220; j++) begin
            i_wdog_kick = (j % 50 == 0);
            applyStimulus();
            checkOutput($sformatf("kick E%0d state", j), 32'(o_state), 3);
        end
        i_wdog_kick = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
